// File: rtl/strip_decoder_if.sv
// Byte write bus produced by strip_decoder; same shape as the strip_controller
// write port so a decoder can feed a controller directly.
interface strip_decoder_if #(
  parameter int ADDR_W = 8
);
  logic              write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [7:0]        write_data;

  modport master (output write_en, write_addr, write_data);
  modport slave  (input  write_en, write_addr, write_data);
endinterface

// File: rtl/strip_decoder.sv
// One-wire LED stream decoder: pulse-width bits to bytes, framed by a latch gap.
// Optional STRIP_DECODER_SYNC_EN adds a 2-flop synchroniser ahead of sampling.
module strip_decoder #(
  parameter int THIRD_CYCLES = 1,
  parameter int LATCH_CYCLES = 50,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_in,
  strip_decoder_if.master   wr,
  output logic              receiving,
  output logic              frame_done,
  output logic [ADDR_W:0]   frame_bytes,
  output logic              err,
  output logic              overflow
);
  localparam int CW = $clog2(LATCH_CYCLES + 1);
  localparam logic [CW-1:0]   LATCH_C    = CW'(LATCH_CYCLES);
  localparam logic [CW-1:0]   HIGH_MAX   = CW'(3 * THIRD_CYCLES);
  localparam logic [CW:0]     THREE_T    = (CW + 1)'(3 * THIRD_CYCLES);
  localparam logic [ADDR_W:0] BYTES_FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    WAIT_GAP = 3'd0,
    IDLE     = 3'd1,
    HIGH     = 3'd2,
    LOW      = 3'd3,
    ERR      = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic              line_s, s_r, s_prev_r, rise_s, fall_s, gap_s, bit_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [7:0]        shift_r, shift_s;
  logic [2:0]        bits_r, bits_s;
  logic [ADDR_W:0]   bytes_r, bytes_s;
  logic              write_en_r, write_en_s;
  logic [ADDR_W-1:0] write_addr_r, write_addr_s;
  logic [7:0]        write_data_r, write_data_s;
  logic              receiving_r, receiving_s;
  logic              frame_done_r, frame_done_s;
  logic [ADDR_W:0]   frame_bytes_r, frame_bytes_s;
  logic              err_r, err_s;
  logic              overflow_r, overflow_s;

`ifdef STRIP_DECODER_SYNC_EN
  logic [1:0] sync_r;

  // two-flop synchroniser for an asynchronous line
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], data_in};
    end
  end
  assign line_s = sync_r[1];
`else
  assign line_s = data_in;
`endif

  assign rise_s = s_r & ~s_prev_r;
  assign fall_s = ~s_r & s_prev_r;
  // cnt_r describes the level now held in s_prev_r
  assign gap_s  = ~s_prev_r & (cnt_r == LATCH_C);
  assign bit_s  = ({cnt_r, 1'b0} > THREE_T);
  assign cnt_s  = (s_r != s_prev_r) ? CW'(1) :
                  ((cnt_r == LATCH_C) ? cnt_r : cnt_r + CW'(1));

  // state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= WAIT_GAP;
    end else begin
      state_r <= state_s;
    end
  end

  // next state, datapath and output next values
  always_comb begin
    state_s       = state_r;
    shift_s       = shift_r;
    bits_s        = bits_r;
    bytes_s       = bytes_r;
    write_en_s    = 1'b0;
    write_addr_s  = write_addr_r;
    write_data_s  = write_data_r;
    receiving_s   = receiving_r;
    frame_done_s  = 1'b0;
    frame_bytes_s = frame_bytes_r;
    err_s         = 1'b0;
    overflow_s    = overflow_r;
    case (state_r)
      WAIT_GAP: begin
        if (gap_s && rise_s) begin
          state_s     = HIGH;
          receiving_s = 1'b1;
        end else if (gap_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_GAP;
        end
      end
      IDLE: begin
        if (rise_s) begin
          state_s     = HIGH;
          receiving_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      HIGH: begin
        if (fall_s) begin
          shift_s = {shift_r[6:0], bit_s};
          bits_s  = bits_r + 3'd1;
          state_s = LOW;
          if (bits_r == 3'd7 && bytes_r == BYTES_FULL) begin
            overflow_s = 1'b1;
          end else if (bits_r == 3'd7) begin
            write_en_s   = 1'b1;
            write_addr_s = bytes_r[ADDR_W-1:0];
            write_data_s = {shift_r[6:0], bit_s};
            bytes_s      = bytes_r + (ADDR_W + 1)'(1);
          end else begin
            write_en_s = 1'b0;
          end
        end else if (cnt_r >= HIGH_MAX) begin
          // this cycle is still high, so the pulse is longer than a bit period
          state_s     = ERR;
          err_s       = 1'b1;
          receiving_s = 1'b0;
          shift_s     = 8'h00;
          bits_s      = 3'd0;
          bytes_s     = '0;
        end else begin
          state_s = HIGH;
        end
      end
      LOW: begin
        if (gap_s) begin
          if (bits_r != 3'd0) begin
            err_s = 1'b1;
          end else if (bytes_r != '0) begin
            frame_done_s  = 1'b1;
            frame_bytes_s = bytes_r;
          end else begin
            frame_done_s = 1'b0;
          end
          shift_s = 8'h00;
          bits_s  = 3'd0;
          bytes_s = '0;
          if (rise_s) begin
            state_s     = HIGH;
            receiving_s = 1'b1;
          end else begin
            state_s     = IDLE;
            receiving_s = 1'b0;
          end
        end else if (rise_s) begin
          state_s = HIGH;
        end else begin
          state_s = LOW;
        end
      end
      ERR: begin
        state_s = WAIT_GAP;
      end
      default: begin
        state_s = WAIT_GAP;
      end
    endcase
  end

  // line sampling, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      s_r           <= 1'b0;
      s_prev_r      <= 1'b0;
      cnt_r         <= '0;
      shift_r       <= 8'h00;
      bits_r        <= 3'd0;
      bytes_r       <= '0;
      write_en_r    <= 1'b0;
      write_addr_r  <= '0;
      write_data_r  <= 8'h00;
      receiving_r   <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_bytes_r <= '0;
      err_r         <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      s_r           <= line_s;
      s_prev_r      <= s_r;
      cnt_r         <= cnt_s;
      shift_r       <= shift_s;
      bits_r        <= bits_s;
      bytes_r       <= bytes_s;
      write_en_r    <= write_en_s;
      write_addr_r  <= write_addr_s;
      write_data_r  <= write_data_s;
      receiving_r   <= receiving_s;
      frame_done_r  <= frame_done_s;
      frame_bytes_r <= frame_bytes_s;
      err_r         <= err_s;
      overflow_r    <= overflow_s;
    end
  end

  assign wr.write_en   = write_en_r;
  assign wr.write_addr = write_addr_r;
  assign wr.write_data = write_data_r;
  assign receiving     = receiving_r;
  assign frame_done    = frame_done_r;
  assign frame_bytes   = frame_bytes_r;
  assign err           = err_r;
  assign overflow      = overflow_r;
endmodule

// File: tb/tb_strip_decoder.sv
// Directed scoreboard bench for strip_decoder: an ADDR_W=8 instance for framing,
// error and reset cases and an ADDR_W=2 instance for overflow.
module tb_strip_decoder;
  localparam logic [18:0] NONE = 19'h7FFFF;

  logic clk = 1'b0;
  logic reset;
  logic line;
  logic use2;
  logic din8, din2;
  logic rcv8, fd8, err8, ovf8;
  logic rcv2, fd2, err2, ovf2;
  logic [8:0] fb8;
  logic [2:0] fb2;
  int vectors = 0;
  int miscompares = 0;
  logic [18:0] exp8[$];
  logic [18:0] exp2[$];

  strip_decoder_if #(.ADDR_W(8)) wr8 ();
  strip_decoder_if #(.ADDR_W(2)) wr2 ();

  assign din8 = use2 ? 1'b0 : line;
  assign din2 = use2 ? line : 1'b0;

  strip_decoder #(.THIRD_CYCLES(1), .LATCH_CYCLES(50), .ADDR_W(8)) dut8 (
    .clk(clk), .reset(reset), .data_in(din8), .wr(wr8),
    .receiving(rcv8), .frame_done(fd8), .frame_bytes(fb8),
    .err(err8), .overflow(ovf8)
  );

  strip_decoder #(.THIRD_CYCLES(1), .LATCH_CYCLES(50), .ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .data_in(din2), .wr(wr2),
    .receiving(rcv2), .frame_done(fd2), .frame_bytes(fb2),
    .err(err2), .overflow(ovf2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [18:0] ev(input logic [1:0] kind, input logic [16:0] val);
    return {kind, val};
  endfunction

  task automatic push(input int id, input logic [18:0] e);
    if (id == 0) exp8.push_back(e);
    else exp2.push_back(e);
  endtask

  task automatic exp_wr(input int id, input logic [7:0] addr, input logic [7:0] data);
    push(id, ev(2'd0, {1'b0, addr, data}));
  endtask

  task automatic exp_fd(input int id, input logic [8:0] n);
    push(id, ev(2'd1, {8'd0, n}));
  endtask

  task automatic exp_err(input int id);
    push(id, ev(2'd2, 17'd0));
  endtask

  task automatic observe(input int id, input string tag, input logic [18:0] obs);
    logic [18:0] e;
    e = NONE;
    if (id == 0) begin
      if (exp8.size() > 0) e = exp8.pop_front();
    end else begin
      if (exp2.size() > 0) e = exp2.pop_front();
    end
    chk(tag, {13'd0, obs}, {13'd0, e});
  endtask

  // pop and compare every output event as it appears
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (wr8.write_en) observe(0, "write8", ev(2'd0, {1'b0, wr8.write_addr, wr8.write_data}));
      if (fd8) observe(0, "frame_done8", ev(2'd1, {8'd0, fb8}));
      if (err8) begin
        observe(0, "err8", ev(2'd2, 17'd0));
        chk("rcv_at_err8", {31'd0, rcv8}, 32'd0);
      end
      if (wr2.write_en) observe(1, "write2", ev(2'd0, {7'd0, wr2.write_addr, wr2.write_data}));
      if (fd2) observe(1, "frame_done2", ev(2'd1, {14'd0, fb2}));
      if (err2) observe(1, "err2", ev(2'd2, 17'd0));
    end
  end

  task automatic send_bit(input logic b);
    repeat (b ? 2 : 1) begin @(negedge clk); line = 1'b1; end
    repeat (b ? 1 : 2) begin @(negedge clk); line = 1'b0; end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(negedge clk); line = 1'b0; end
  endtask

  task automatic chk_idle8(input string tag);
    chk({tag, "_we"}, {31'd0, wr8.write_en}, 32'd0);
    chk({tag, "_addr"}, {24'd0, wr8.write_addr}, 32'd0);
    chk({tag, "_data"}, {24'd0, wr8.write_data}, 32'd0);
    chk({tag, "_rcv"}, {31'd0, rcv8}, 32'd0);
    chk({tag, "_fd"}, {31'd0, fd8}, 32'd0);
    chk({tag, "_fb"}, {23'd0, fb8}, 32'd0);
    chk({tag, "_err"}, {31'd0, err8}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, ovf8}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    line  = 1'b0;
    use2  = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle8("reset");
    reset = 1'b1;
    gap(60);

    // single byte A5
    exp_wr(0, 8'd0, 8'hA5);
    exp_fd(0, 9'd1);
    send_byte(8'hA5);
    chk("rcv_in_frame", {31'd0, rcv8}, 32'd1);
    gap(55);
    chk("rcv_after_frame", {31'd0, rcv8}, 32'd0);
    chk("fb_a5", {23'd0, fb8}, 32'd1);

    // three back-to-back bytes
    exp_wr(0, 8'd0, 8'hFF);
    exp_wr(0, 8'd1, 8'h00);
    exp_wr(0, 8'd2, 8'h3C);
    exp_fd(0, 9'd3);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h3C);
    gap(55);

    // partial byte at latch gap, then a clean frame restarting at addr 0
    exp_err(0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    gap(55);
    chk("fb_held_after_err", {23'd0, fb8}, 32'd3);
    exp_wr(0, 8'd0, 8'h81);
    exp_fd(0, 9'd1);
    send_byte(8'h81);
    gap(55);

    // over-long high pulse; following bits ignored until a full gap
    exp_err(0);
    repeat (4) begin @(negedge clk); line = 1'b1; end
    gap(2);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    gap(60);
    exp_wr(0, 8'd0, 8'h12);
    exp_fd(0, 9'd1);
    send_byte(8'h12);
    gap(55);
    chk("ovf8_clear", {31'd0, ovf8}, 32'd0);

    // ADDR_W=2: fifth byte overflows
    use2 = 1'b1;
    gap(60);
    exp_wr(1, 8'd0, 8'h11);
    exp_wr(1, 8'd1, 8'h22);
    exp_wr(1, 8'd2, 8'h33);
    exp_wr(1, 8'd3, 8'h44);
    exp_fd(1, 9'd4);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    gap(55);
    chk("ovf2_set", {31'd0, ovf2}, 32'd1);
    chk("fb2_sat", {29'd0, fb2}, 32'd4);
    exp_wr(1, 8'd0, 8'h66);
    exp_fd(1, 9'd1);
    send_byte(8'h66);
    gap(55);
    chk("ovf2_sticky", {31'd0, ovf2}, 32'd1);
    use2 = 1'b0;
    gap(5);

    // reset mid-byte, activity ignored until a full gap
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("rcv_before_reset", {31'd0, rcv8}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle8("midreset");
    chk("ovf2_reset", {31'd0, ovf2}, 32'd0);
    reset = 1'b1;
    send_byte(8'hFF);
    gap(60);
    exp_wr(0, 8'd0, 8'h5A);
    exp_fd(0, 9'd1);
    send_byte(8'h5A);
    gap(55);

    chk("pending8", exp8.size(), 32'd0);
    chk("pending2", exp2.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/strip_decoder.md
Name: strip_decoder

Overview:
- Receive-side counterpart of strip_controller: samples the one-wire LED stream that strip_controller drives on data_out and decodes the pulse-width-coded bits into bytes.
- Writes each decoded byte through the same write_en/write_addr/write_data port shape that strip_controller accepts, so a decoder can be chained straight into a second strip_controller.
- Used for loopback self-test and for strip chaining.

Parameters:
- THIRD_CYCLES, 1, clk cycles per third of a bit period (bit period = 3*THIRD_CYCLES).
- LATCH_CYCLES, 50, consecutive low cycles that mark end-of-frame (latch gap); must exceed 3*THIRD_CYCLES.
- ADDR_W, 8, width of write_addr.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- data_in  in  1  serial LED line (strip_controller data_out)
- write_en  out  1  one-cycle pulse: write_data/write_addr valid
- write_addr  out  ADDR_W  byte index within current frame
- write_data  out  8  decoded byte, MSB received first
- receiving  out  1  high from first rising edge of a frame until frame_done/error
- frame_done  out  1  one-cycle pulse at latch detection after a valid frame
- frame_bytes  out  ADDR_W+1  byte count of last completed frame; held until next frame_done
- err  out  1  one-cycle pulse on protocol error
- overflow  out  1  sticky; set when a frame exceeds 2^ADDR_W bytes; cleared only by reset

Behaviour:
- Reset (reset==0 at posedge): state WAIT_GAP; all outputs 0; counters, shift register and bit count cleared. Reset mid-frame discards all partial data.
- s = sampled line; s_prev = s registered. Rise: s & ~s_prev. Fall: ~s & s_prev. cnt counts cycles the current level has been stable and saturates at LATCH_CYCLES.
- WAIT_GAP: ignore data. When the low count reaches LATCH_CYCLES -> IDLE. Any rise clears the low count.
- IDLE: rise -> HIGH, receiving=1, cnt=1.
- HIGH: cnt++ while s==1.
  - If cnt exceeds 3*THIRD_CYCLES -> ERR.
  - On fall with high count h: bit = (2*h > 3*THIRD_CYCLES). Shift bit into the LSB of an 8-bit shift register; bits++; -> LOW.
- LOW:
  - rise -> HIGH.
  - Low count reaches LATCH_CYCLES -> end-of-frame:
    - bits%8==0 and bytes>0: frame_done pulse, frame_bytes=bytes, -> IDLE.
    - bits%8!=0: err pulse, no frame_done, -> IDLE.
    - Clear receiving, bits, bytes and write_addr counter.
- Byte completion: on the cycle the 8th bit of a byte is shifted in, the next posedge asserts write_en=1 for exactly one cycle, with write_data=byte and write_addr=bytes[ADDR_W-1:0]; bytes then increments.
  - bytes==2^ADDR_W at completion: suppress write_en, set overflow, keep decoding to the latch gap.
  - frame_done still pulses; frame_bytes saturates at 2^ADDR_W.
- ERR: err pulses one cycle, receiving=0, partial byte dropped, bytes cleared -> WAIT_GAP. The decoder resynchronises only after a full latch gap.
- Latency: data_in fall to write_en = 2 cycles (1 sample register + 1 output register) without the optional feature.
- Simultaneous events: a fall in the same cycle as the high-too-long check is judged on cnt before the increment. A rise exactly when the low count reaches LATCH_CYCLES is treated as end-of-frame first, and that rise starts the next frame in the same cycle (IDLE handling).

Optional Feature:
- Macro STRIP_DECODER_SYNC_EN.
- Defined: data_in passes through a 2-flop synchroniser before s. Latency grows by 2 cycles (fall to write_en = 4). Pulse-width decoding is unchanged.
- Undefined: s is a single register of data_in; suitable only when data_in is synchronous to clk.

Test Plan:
- THIRD_CYCLES=1, after a 50-cycle low gap, send bits 1,0,1,0,0,1,0,1 (high 2/low 1 for '1', high 1/low 2 for '0'), then 50 low cycles -> one write_en with write_data=8'hA5, write_addr=0; then frame_done=1 and frame_bytes=1.
- Three bytes 8'hFF, 8'h00, 8'h3C back-to-back, then latch -> write_en at addr 0,1,2 with those values; frame_done=1, frame_bytes=3; the next frame starts again at addr 0.
- 5 bits then 50 low -> err pulse, no write_en, no frame_done; a subsequent valid 8'h81 frame decodes to addr 0.
- High held 4 cycles (THIRD_CYCLES=1) -> err pulse, receiving=0; bits sent before a 50-cycle gap are ignored; after the gap, 8'h12 decodes correctly.
- ADDR_W=2, send 5 bytes -> write_en only for bytes 0..3; overflow=1 and stays 1; frame_done with frame_bytes=4.
- Assert reset mid-byte -> all outputs 0 next cycle; line activity ignored until a 50-cycle low gap; then 8'h5A decodes at addr 0.
